// File: rtl/qpu_pwr_pkg.sv
// Shared definitions for the QPU power sequencer: FSM encodings, counter width
// and the legal ranges of the timing parameters.
package qpu_pwr_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } seq_state_e;

  localparam int CNT_W = 4;

  localparam int HOLD_CYC_MIN = 0;
  localparam int HOLD_CYC_MAX = 15;
  localparam int WAKE_DLY_MIN = 1;
  localparam int WAKE_DLY_MAX = 15;

endpackage

// File: rtl/qpu_act_hold.sv
// Single-unit idle hysteresis: keeps the activity indication high for HOLD_CYC
// cycles after the raw signal falls, with zero latency on the rising edge.
module qpu_act_hold
  import qpu_pwr_pkg::*;
#(
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  output logic active_h_o
);

  if ((HOLD_CYC < HOLD_CYC_MIN) || (HOLD_CYC > HOLD_CYC_MAX)) begin : g_bad_hold
    $error("qpu_act_hold: HOLD_CYC out of range");
  end

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (active_i) begin
      cnt_d = HOLD_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_h_o = active_i | (cnt_q != '0);

endmodule

// File: rtl/qpu_sleep_seq.sv
// WFI sleep/wake sequencer feeding the core clock-gating controller, plus
// per-unit activity hysteresis for the unit clock gates.
module qpu_sleep_seq
  import qpu_pwr_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int WAKE_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wfi_req,
  output logic       wfi_ack,
  input  logic       irq_pending,
  input  logic       dbg_req,
  input  logic       ifu_active,
  input  logic       exu_active,
  input  logic       lsu_active,
  input  logic       biu_active,
  output logic       ifu_active_h,
  output logic       exu_active_h,
  output logic       lsu_active_h,
  output logic       biu_active_h,
  output logic       core_wfi,
  output logic       wake_pulse,
  output logic [1:0] seq_state
);

  if ((WAKE_DLY < WAKE_DLY_MIN) || (WAKE_DLY > WAKE_DLY_MAX)) begin : g_bad_wake
    $error("qpu_sleep_seq: WAKE_DLY out of range");
  end

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_DLY);

  logic [3:0] act_raw;
  logic [3:0] act_hold;

  assign act_raw = {biu_active, lsu_active, exu_active, ifu_active};

  for (genvar gi = 0; gi < 4; gi++) begin : g_hold
    qpu_act_hold #(
      .HOLD_CYC (HOLD_CYC)
    ) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .active_i   (act_raw[gi]),
      .active_h_o (act_hold[gi])
    );
  end

  assign ifu_active_h = act_hold[0];
  assign exu_active_h = act_hold[1];
  assign lsu_active_h = act_hold[2];
  assign biu_active_h = act_hold[3];

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             ack_q, ack_d;
  logic             wp_q, wp_d;
  logic             wfi_q, wfi_d;
  logic             wake;

  assign wake = irq_pending | dbg_req;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ack_d   = 1'b0;
    wp_d    = 1'b0;
    unique case (state_q)
      // A request still visible during its own ack cycle is the retiring one.
      ST_RUN: begin
        if (wfi_req && !ack_q) begin
          if (wake) ack_d = 1'b1;
          else      state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wake) begin
          state_d = ST_RUN;
          ack_d   = 1'b1;
        end else if (!wfi_req) begin
          state_d = ST_RUN;
        end else if (!lsu_active && !biu_active) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (wake) begin
          state_d = ST_WAKE;
          wcnt_d  = WAKE_LD;
        end
      end
      ST_WAKE: begin
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
          ack_d   = 1'b1;
          wp_d    = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    wfi_d = (state_d == ST_SLEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
      wp_q    <= 1'b0;
      wfi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      wp_q    <= wp_d;
      wfi_q   <= wfi_d;
    end
  end

  assign wfi_ack    = ack_q;
  assign wake_pulse = wp_q;
  assign core_wfi   = wfi_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_qpu_sleep_seq.sv
// Bench for qpu_sleep_seq: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed cycle expectations.
module tb_qpu_sleep_seq;

  localparam int HOLD = 4;
  localparam int WDLY = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wfi_req = 1'b0;
  logic       irq_pending = 1'b0;
  logic       dbg_req = 1'b0;
  logic [3:0] act = 4'b0;  // 0 ifu, 1 exu, 2 lsu, 3 biu

  logic       wfi_ack, core_wfi, wake_pulse;
  logic [1:0] seq_state;
  logic [3:0] h0;
  logic       wfi_ack1, core_wfi1, wake_pulse1;
  logic [1:0] seq_state1;
  logic [3:0] h1;

  qpu_sleep_seq #(.HOLD_CYC(HOLD), .WAKE_DLY(WDLY)) dut (
    .clk(clk), .rst_n(rst_n), .wfi_req(wfi_req), .wfi_ack(wfi_ack),
    .irq_pending(irq_pending), .dbg_req(dbg_req),
    .ifu_active(act[0]), .exu_active(act[1]), .lsu_active(act[2]), .biu_active(act[3]),
    .ifu_active_h(h0[0]), .exu_active_h(h0[1]), .lsu_active_h(h0[2]), .biu_active_h(h0[3]),
    .core_wfi(core_wfi), .wake_pulse(wake_pulse), .seq_state(seq_state)
  );

  qpu_sleep_seq #(.HOLD_CYC(0), .WAKE_DLY(WDLY)) dut_pt (
    .clk(clk), .rst_n(rst_n), .wfi_req(wfi_req), .wfi_ack(wfi_ack1),
    .irq_pending(irq_pending), .dbg_req(dbg_req),
    .ifu_active(act[0]), .exu_active(act[1]), .lsu_active(act[2]), .biu_active(act[3]),
    .ifu_active_h(h1[0]), .exu_active_h(h1[1]), .lsu_active_h(h1[2]), .biu_active_h(h1[3]),
    .core_wfi(core_wfi1), .wake_pulse(wake_pulse1), .seq_state(seq_state1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: phase numbers follow the documented state encodings; the
  // wake exit is a precomputed release cycle; hysteresis uses the last cycle
  // each unit was seen active.
  int m_phase = 0;
  int m_release = 0;
  bit m_ack = 1'b0;
  bit m_wp = 1'b0;
  int last_act [4] = '{-100, -100, -100, -100};

  always @(posedge clk or negedge rst_n) begin
    bit wake, n_ack, n_wp;
    if (!rst_n) begin
      m_phase = 0;
      m_ack   = 1'b0;
      m_wp    = 1'b0;
      for (int i = 0; i < 4; i++) last_act[i] = -100;
    end else begin
      wake  = irq_pending | dbg_req;
      n_ack = 1'b0;
      n_wp  = 1'b0;
      case (m_phase)
        0: if (wfi_req && !m_ack) begin
             if (wake) n_ack = 1'b1;
             else      m_phase = 1;
           end
        1: if (wake) begin m_phase = 0; n_ack = 1'b1; end
           else if (!wfi_req) m_phase = 0;
           else if (!act[2] && !act[3]) m_phase = 2;
        2: if (wake) begin m_phase = 3; m_release = cyc + 1 + WDLY; end
        default: if (cyc + 1 == m_release) begin m_phase = 0; n_ack = 1'b1; n_wp = 1'b1; end
      endcase
      m_ack = n_ack;
      m_wp  = n_wp;
      for (int i = 0; i < 4; i++) if (act[i]) last_act[i] = cyc;
    end
  end

  function automatic bit exp_h(input int u);
    return act[u] || ((cyc - last_act[u]) <= HOLD);
  endfunction

  always @(negedge clk) begin
    #2;
    chk("state", {2'b0, seq_state}, 4'(m_phase));
    chk("core_wfi", {3'b0, core_wfi}, {3'b0, (m_phase == 2)});
    chk("wfi_ack", {3'b0, wfi_ack}, {3'b0, m_ack});
    chk("wake_pulse", {3'b0, wake_pulse}, {3'b0, m_wp});
    for (int u = 0; u < 4; u++) begin
      chk("active_h", {3'b0, h0[u]}, {3'b0, exp_h(u)});
      chk("active_h_passthru", {3'b0, h1[u]}, {3'b0, act[u]});
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("L_rst_state", {2'b0, seq_state}, 4'd0);
    chk("L_rst_wfi", {3'b0, core_wfi}, 4'd0);
    chk("L_rst_ack", {3'b0, wfi_ack}, 4'd0);
    chk("L_rst_h", h0, 4'd0);

    // Sleep entry then irq wake
    goto(10); wfi_req = 1'b1; #3 chk("L_A_run", {2'b0, seq_state}, 4'd0);
    goto(11); #3 chk("L_A_drain", {2'b0, seq_state}, 4'd1);
    goto(12); #3 chk("L_A_sleep_wfi", {3'b0, core_wfi}, 4'd1);
    goto(20); irq_pending = 1'b1; #3 chk("L_A_still_wfi", {3'b0, core_wfi}, 4'd1);
    goto(21); irq_pending = 1'b0; #3 chk("L_A_wake_wfi", {3'b0, core_wfi}, 4'd0);
    chk("L_A_wake_state", {2'b0, seq_state}, 4'd3);
    goto(22); #3 chk("L_A_wake2", {2'b0, seq_state}, 4'd3);
    goto(23); #3 chk("L_A_ack", {3'b0, wfi_ack}, 4'd1);
    chk("L_A_wp", {3'b0, wake_pulse}, 4'd1);
    goto(24); wfi_req = 1'b0; #3 chk("L_A_ack_one", {3'b0, wfi_ack}, 4'd0);

    // WFI with pending irq retires as a NOP
    goto(30); wfi_req = 1'b1; irq_pending = 1'b1;
    goto(31); wfi_req = 1'b0; irq_pending = 1'b0;
    #3 chk("L_B_ack", {3'b0, wfi_ack}, 4'd1);
    chk("L_B_state", {2'b0, seq_state}, 4'd0);
    goto(32); #3 chk("L_B_ack_one", {3'b0, wfi_ack}, 4'd0);
    chk("L_B_nowfi", {3'b0, core_wfi}, 4'd0);

    // LSU busy keeps DRAIN for 8 cycles, then dbg wake
    goto(40); wfi_req = 1'b1; act[2] = 1'b1;
    goto(41); #3 chk("L_C_drain1", {2'b0, seq_state}, 4'd1);
    goto(48); act[2] = 1'b0; #3 chk("L_C_drain8", {2'b0, seq_state}, 4'd1);
    goto(49); dbg_req = 1'b1; #3 chk("L_C_sleep", {2'b0, seq_state}, 4'd2);
    goto(50); dbg_req = 1'b0; #3 chk("L_C_wake", {2'b0, seq_state}, 4'd3);
    goto(52); #3 chk("L_C_ack", {3'b0, wfi_ack}, 4'd1);
    goto(53); wfi_req = 1'b0;

    // dbg abort while draining
    goto(60); wfi_req = 1'b1; act[3] = 1'b1;
    goto(61); #3 chk("L_D_drain", {2'b0, seq_state}, 4'd1);
    goto(62); dbg_req = 1'b1;
    goto(63); dbg_req = 1'b0; wfi_req = 1'b0; act[3] = 1'b0;
    #3 chk("L_D_ack", {3'b0, wfi_ack}, 4'd1);
    chk("L_D_run", {2'b0, seq_state}, 4'd0);
    chk("L_D_nowp", {3'b0, wake_pulse}, 4'd0);

    // Flush in DRAIN: back to RUN with no ack
    goto(70); wfi_req = 1'b1; act[2] = 1'b1;
    goto(71); wfi_req = 1'b0; #3 chk("L_E_drain", {2'b0, seq_state}, 4'd1);
    goto(72); #3 chk("L_E_run", {2'b0, seq_state}, 4'd0);
    chk("L_E_noack", {3'b0, wfi_ack}, 4'd0);
    goto(73); act[2] = 1'b0; #3 chk("L_E_noack2", {3'b0, wfi_ack}, 4'd0);

    // Hysteresis release and reload
    goto(80); act[1] = 1'b1;
    goto(90); act[1] = 1'b0; #3 chk("L_H_f", {3'b0, h0[1]}, 4'd1);
    chk("L_H_pt", {3'b0, h1[1]}, 4'd0);
    goto(93); #3 chk("L_H_f3", {3'b0, h0[1]}, 4'd1);
    goto(94); #3 chk("L_H_f4", {3'b0, h0[1]}, 4'd0);
    goto(100); act[1] = 1'b1;
    goto(101); act[1] = 1'b0;
    goto(103); act[1] = 1'b1;
    goto(104); act[1] = 1'b0;
    goto(105); #3 chk("L_H_reload", {3'b0, h0[1]}, 4'd1);
    goto(107); #3 chk("L_H_r3", {3'b0, h0[1]}, 4'd1);
    goto(108); #3 chk("L_H_r4", {3'b0, h0[1]}, 4'd0);

    // Async reset while asleep
    goto(120); wfi_req = 1'b1; act[0] = 1'b1; act[1] = 1'b1;
    goto(122); #3 chk("L_R_sleep", {3'b0, core_wfi}, 4'd1);
    goto(123); act = 4'b0; #3 chk("L_R_hold", {3'b0, h0[1]}, 4'd1);
    #1 rst_n = 1'b0; wfi_req = 1'b0;
    #1 chk("L_R_async_wfi", {3'b0, core_wfi}, 4'd0);
    chk("L_R_async_state", {2'b0, seq_state}, 4'd0);
    chk("L_R_cnt_clear", h0, 4'd0);
    goto(125); rst_n = 1'b1;
    #3 chk("L_R_run", {2'b0, seq_state}, 4'd0);
    chk("L_R_noack", {3'b0, wfi_ack}, 4'd0);
    goto(130); #3 chk("L_R_end", {3'b0, wfi_ack | core_wfi}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpu_sleep_seq.md
# qpu_sleep_seq

Sleep/wake sequencer that drives the core clock-gating controller's `core_wfi` input and the per-unit activity inputs. It turns an EXU-issued WFI request into a drain, sleep and wake sequence with an acknowledge handshake. It also adds idle hysteresis to each unit's activity signal so unit clocks do not gate on and off every cycle. It sits between the EXU/LSU/BIU/IFU activity sources and the clock controller.

## Interface
Parameters:
- `HOLD_CYC`, default 4: idle-hysteresis length in cycles; 0 means pass-through; legal range 0..15.
- `WAKE_DLY`, default 2: cycles spent in WAKE before the core is released; legal range 1..15.

Ports:
- `clk`  in  1  core clock, ungated (always-on)
- `rst_n`  in  1  reset; asynchronous, active-low
- `wfi_req`  in  1  EXU has committed a WFI; level, held until `wfi_ack` or flush
- `wfi_ack`  out  1  one-cycle pulse: the WFI has retired (slept or aborted)
- `irq_pending`  in  1  wake source: any enabled interrupt pending
- `dbg_req`  in  1  wake source: debug halt request
- `ifu_active`, `exu_active`, `lsu_active`, `biu_active`  in  1 each  raw unit activity
- `ifu_active_h`, `exu_active_h`, `lsu_active_h`, `biu_active_h`  out  1 each  hysteresis-extended activity, fed to the clock controller
- `core_wfi`  out  1  sleep indication to the clock controller; registered
- `wake_pulse`  out  1  one-cycle pulse on the first RUN cycle after a sleep
- `seq_state`  out  2  current FSM state, for debug/CSR readback

## Operation
- `wake = irq_pending | dbg_req`.
- FSM state encodings: RUN=0, DRAIN=1, SLEEP=2, WAKE=3. Reset state is RUN.
- RUN transitions:
  - `wfi_req & ~wake & ~wfi_ack` → DRAIN.
  - `wfi_req & wake` → stay in RUN and pulse `wfi_ack` next cycle (the WFI retires as a NOP).
  - `wfi_req` is ignored in any cycle where `wfi_ack` is high.
- DRAIN transitions:
  - `wake` → RUN with `wfi_ack`. Wake takes priority over the idle check.
  - `~wfi_req` (pipeline flush) → RUN with no ack.
  - `~lsu_active & ~biu_active` → SLEEP. Raw signals are used here, not the hysteresis versions.
  - Otherwise stay in DRAIN. There is no timeout.
- SLEEP transitions:
  - `core_wfi` = 1 throughout.
  - `wake` → WAKE and load the wake counter with `WAKE_DLY`.
  - `wfi_req` is ignored.
- WAKE transitions:
  - Counter decrements each cycle.
  - When the counter is 1 → RUN, asserting `wfi_ack` and `wake_pulse` in the first RUN cycle.
  - Wake inputs are ignored.
- `core_wfi` is registered: 1 exactly in cycles where the state is SLEEP.
- Hysteresis, per unit, using a 4-bit counter:
  - While `active` = 1, the counter loads `HOLD_CYC`.
  - Otherwise it decrements, saturating at 0.
  - `active_h = active | (cnt != 0)`.
  - Counters run in every FSM state.
- Width rules:
  - The wake counter is 4 bits.
  - A `HOLD_CYC` or `WAKE_DLY` outside its legal range is an elaboration error.

## Timing
- Reset values: state RUN; `core_wfi`, `wfi_ack` and `wake_pulse` all 0; all counters 0; each `*_active_h` equals its raw input.
- Asserting `rst_n` low mid-sequence returns the FSM to RUN asynchronously and drops `core_wfi` immediately. No `wfi_ack` is issued for the lost WFI.
- Sleep entry: `wfi_req` seen at cycle t with LSU/BIU idle → DRAIN at t+1 → SLEEP and `core_wfi`=1 at t+2.
- Wake: `wake` sampled at cycle s in SLEEP → WAKE with `core_wfi`=0 at s+1 → RUN with `wfi_ack`=`wake_pulse`=1 at s+1+`WAKE_DLY`.
- Abort in DRAIN: `wake` at cycle d → RUN with `wfi_ack`=1 at d+1.
- Handshake: `wfi_ack` is exactly one cycle. EXU drops `wfi_req` no later than the cycle after the ack.
- Hysteresis release: after `active` falls at cycle f, `active_h` stays 1 through cycle f+`HOLD_CYC`-1 and is 0 from f+`HOLD_CYC`. It is combinational in the raw input, so the rising edge has zero latency.

## Structure
- Package `qpu_pwr_pkg` holds:
  - the state encodings RUN/DRAIN/SLEEP/WAKE;
  - the counter width constant 4;
  - the parameter range limits.
- Sub-module `qpu_act_hold`: a single-unit hysteresis counter, parameterised by `HOLD_CYC`, instantiated four times.
- The top level contains the FSM, the wake counter and the output registers only.

## Test plan
- Reset, idle inputs, `wfi_req` pulse at t=10 with LSU/BIU idle → `core_wfi`=1 from t=12. `irq_pending` at t=20 → `core_wfi`=0 at t=21, `wfi_ack`=`wake_pulse`=1 at t=23 (`WAKE_DLY`=2).
- `wfi_req` and `irq_pending` together in RUN at t=5 → `wfi_ack` at t=6, `core_wfi` never asserts, `seq_state` stays 0.
- `lsu_active` held high for 8 cycles after `wfi_req` → FSM stays in DRAIN for 8 cycles, then SLEEP. `dbg_req` during DRAIN instead → RUN with ack next cycle.
- `wfi_req` dropped while in DRAIN → RUN, no `wfi_ack`, no `core_wfi`.
- `exu_active` 1→0 at t=30 with `HOLD_CYC`=4 → `exu_active_h` 1 through t=33, 0 at t=34. Re-assert at t=32 → stays 1 and the counter reloads. With `HOLD_CYC`=0 → output equals input.
- `rst_n` low while in SLEEP → `core_wfi` drops asynchronously. After release, state is RUN and all counters are 0.
